// File: rtl/dram_bank_sched_fsm.sv
// DRAM command sequencer: one request at a time, open-page row tracking, ACT/RD/WR/PRE/PREA/REF honouring tRCD/tRP/tRFC/CAS.
// Commands appear the cycle after acceptance or wait expiry; req_ready stays low from acceptance through the RD/WR cycle and while a refresh is pending.
module dram_bank_sched_fsm #(
  parameter int NUMBER_OF_BANKS = 8,
  parameter int NUMBER_OF_ROWS  = 128,
  parameter int NUMBER_OF_COLS  = 8,
  parameter int T_RCD           = 2,
  parameter int T_RP            = 2,
  parameter int T_RFC           = 8,
  parameter int T_CAS           = 2,
  localparam int BW = $clog2(NUMBER_OF_BANKS),
  localparam int RW = $clog2(NUMBER_OF_ROWS),
  localparam int CW = $clog2(NUMBER_OF_COLS)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [BW-1:0] req_bank,
  input  logic [RW-1:0] req_row,
  input  logic [CW-1:0] req_col,
  input  logic          refresh_flag,
  output logic          refresh_ack,
  output logic [2:0]    cmd,
  output logic [BW-1:0] cmd_bank,
  output logic [RW-1:0] cmd_row,
  output logic [CW-1:0] cmd_col,
  output logic          rd_valid,
  output logic          busy
);

  localparam int TMAX = (T_RCD > T_RP) ? ((T_RCD > T_RFC) ? T_RCD : T_RFC)
                                       : ((T_RP > T_RFC) ? T_RP : T_RFC);
  localparam int CNTW = $clog2(TMAX + 1);
  localparam logic [CNTW-1:0] RCD_LD = CNTW'(T_RCD - 1);
  localparam logic [CNTW-1:0] RP_LD  = CNTW'(T_RP - 1);
  localparam logic [CNTW-1:0] RFC_LD = CNTW'(T_RFC - 1);

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] CMD_ACT  = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [2:0] CMD_WR   = 3'd3;
  localparam logic [2:0] CMD_PRE  = 3'd4;
  localparam logic [2:0] CMD_PREA = 3'd5;
  localparam logic [2:0] CMD_REF  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RW, S_PREA, S_WAIT_RFC
  } state_t;

  state_t state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            rp_ref_q, rp_ref_d;
  logic            pend_q, pend_d;
  logic            lat_we_q;
  logic [BW-1:0]   lat_bank_q;
  logic [RW-1:0]   lat_row_q;
  logic [CW-1:0]   lat_col_q;
  logic            nxt_we;
  logic [BW-1:0]   nxt_bank;
  logic [RW-1:0]   nxt_row;
  logic [CW-1:0]   nxt_col;
  logic [NUMBER_OF_BANKS-1:0] open_vld_q;
  logic [RW-1:0]   open_row_q [NUMBER_OF_BANKS];
  logic            accept, bank_open, bank_hit;
  logic [2:0]      cmd_d;
  logic [BW-1:0]   bank_d;
  logic [RW-1:0]   row_d;
  logic [CW-1:0]   col_d;
  logic            ready_d, busy_d, rd_now;
  logic [T_CAS-1:0] cas_pipe_q;

  assign bank_open = open_vld_q[req_bank];
  assign bank_hit  = bank_open && (open_row_q[req_bank] == req_row);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rp_ref_d = rp_ref_q;
    accept   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          if (|open_vld_q) begin
            state_d  = S_PREA;
            cnt_d    = RP_LD;
            rp_ref_d = 1'b1;
          end else begin
            state_d = S_WAIT_RFC;
            cnt_d   = RFC_LD;
          end
        end else if (req_valid && req_ready) begin
          accept = 1'b1;
          if (bank_hit) begin
            state_d = S_RW;
          end else if (bank_open) begin
            state_d  = S_PRE;
            cnt_d    = RP_LD;
            rp_ref_d = 1'b0;
          end else begin
            state_d = S_ACT;
            cnt_d   = RCD_LD;
          end
        end
      end
      // tRP countdown starts in the PRE/PREA cycle itself
      S_PRE, S_PREA, S_WAIT_RP: begin
        if (cnt_q == '0) begin
          if (rp_ref_q) begin
            state_d = S_WAIT_RFC;
            cnt_d   = RFC_LD;
          end else begin
            state_d = S_ACT;
            cnt_d   = RCD_LD;
          end
        end else begin
          state_d = S_WAIT_RP;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      S_ACT, S_WAIT_RCD: begin
        if (cnt_q == '0) begin
          state_d = S_RW;
        end else begin
          state_d = S_WAIT_RCD;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      S_RW: state_d = S_IDLE;
      S_WAIT_RFC: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command for the cycle the FSM is entering, so it registers alongside state_q.
  always_comb begin
    nxt_we   = accept ? req_we   : lat_we_q;
    nxt_bank = accept ? req_bank : lat_bank_q;
    nxt_row  = accept ? req_row  : lat_row_q;
    nxt_col  = accept ? req_col  : lat_col_q;
    cmd_d    = CMD_NOP;
    bank_d   = '0;
    row_d    = '0;
    col_d    = '0;
    case (state_d)
      S_PRE: begin
        cmd_d  = CMD_PRE;
        bank_d = nxt_bank;
      end
      S_ACT: begin
        cmd_d  = CMD_ACT;
        bank_d = nxt_bank;
        row_d  = nxt_row;
      end
      S_RW: begin
        cmd_d  = nxt_we ? CMD_WR : CMD_RD;
        bank_d = nxt_bank;
        col_d  = nxt_col;
      end
      S_PREA: cmd_d = CMD_PREA;
      S_WAIT_RFC: begin
        if (state_q != S_WAIT_RFC) cmd_d = CMD_REF;
      end
      default: cmd_d = CMD_NOP;
    endcase
    pend_d  = refresh_flag | (pend_q & (cmd_d != CMD_REF));
    ready_d = (state_d == S_IDLE) & ~pend_d;
    busy_d  = (state_d != S_IDLE) | pend_d;
    rd_now  = (cmd == CMD_RD);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rp_ref_q    <= 1'b0;
      pend_q      <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_bank_q  <= '0;
      lat_row_q   <= '0;
      lat_col_q   <= '0;
      open_vld_q  <= '0;
      for (int i = 0; i < NUMBER_OF_BANKS; i++) open_row_q[i] <= '0;
      cmd         <= CMD_NOP;
      cmd_bank    <= '0;
      cmd_row     <= '0;
      cmd_col     <= '0;
      refresh_ack <= 1'b0;
      req_ready   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rp_ref_q    <= rp_ref_d;
      pend_q      <= pend_d;
      if (accept) begin
        lat_we_q   <= req_we;
        lat_bank_q <= req_bank;
        lat_row_q  <= req_row;
        lat_col_q  <= req_col;
      end
      case (cmd_d)
        CMD_PRE:  open_vld_q[bank_d] <= 1'b0;
        CMD_ACT: begin
          open_vld_q[bank_d] <= 1'b1;
          open_row_q[bank_d] <= row_d;
        end
        CMD_PREA: open_vld_q <= '0;
        default:  ;
      endcase
      cmd         <= cmd_d;
      cmd_bank    <= bank_d;
      cmd_row     <= row_d;
      cmd_col     <= col_d;
      refresh_ack <= (cmd_d == CMD_REF);
      req_ready   <= ready_d;
      busy        <= busy_d;
    end
  end

  generate
    if (T_CAS == 1) begin : g_cas_one
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) cas_pipe_q <= '0;
        else        cas_pipe_q <= rd_now;
      end
    end else begin : g_cas_deep
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) cas_pipe_q <= '0;
        else        cas_pipe_q <= {cas_pipe_q[T_CAS-2:0], rd_now};
      end
    end
  endgenerate

  assign rd_valid = cas_pipe_q[T_CAS-1];

endmodule

// File: tb/tb_dram_bank_sched_fsm.sv
// Bench for dram_bank_sched_fsm: directed scenarios then random traffic, all checked cycle by cycle
// against a transaction-level schedule of expected commands.
module tb_dram_bank_sched_fsm;
  localparam int NB = 8, NR = 128, NC = 8;
  localparam int T_RCD = 2, T_RP = 2, T_RFC = 8, T_CAS = 2;
  localparam int BW = $clog2(NB), RW = $clog2(NR), CW = $clog2(NC);
  localparam int MAXC = 16384;
  localparam int C_NOP = 0, C_ACT = 1, C_RD = 2, C_WR = 3, C_PRE = 4, C_PREA = 5, C_REF = 6;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          req_valid, req_ready, req_we;
  logic [BW-1:0] req_bank;
  logic [RW-1:0] req_row;
  logic [CW-1:0] req_col;
  logic          refresh_flag, refresh_ack;
  logic [2:0]    cmd;
  logic [BW-1:0] cmd_bank;
  logic [RW-1:0] cmd_row;
  logic [CW-1:0] cmd_col;
  logic          rd_valid, busy;

  dram_bank_sched_fsm #(
    .NUMBER_OF_BANKS(NB), .NUMBER_OF_ROWS(NR), .NUMBER_OF_COLS(NC),
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC), .T_CAS(T_CAS)
  ) dut (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .refresh_flag(refresh_flag), .refresh_ack(refresh_ack), .cmd(cmd),
    .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: expected command per cycle, open-page table, refresh pending.
  int  e_cmd [MAXC];
  int  e_bank[MAXC];
  int  e_row [MAXC];
  int  e_col [MAXC];
  bit  e_rdv [MAXC];
  bit  ovld  [NB];
  int  orow  [NB];
  int  t, idle_at;
  bit  pend, accepted, rnd_ref;
  int  checks = 0, errors = 0, ack_obs = 0;

  task automatic clear_model();
    for (int i = 0; i < MAXC; i++) begin
      e_cmd[i] = C_NOP; e_bank[i] = 0; e_row[i] = 0; e_col[i] = 0; e_rdv[i] = 1'b0;
    end
    for (int b = 0; b < NB; b++) begin
      ovld[b] = 1'b0; orow[b] = 0;
    end
    t = 0; idle_at = 0; pend = 1'b0;
  endtask

  task automatic sched(input int c, input int cm, input int b, input int r, input int co);
    e_cmd[c] = cm; e_bank[c] = b; e_row[c] = r; e_col[c] = co;
    if (cm == C_RD) e_rdv[c + T_CAS] = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  // One cycle: check outputs of cycle t, then advance the model on the inputs of cycle t.
  task automatic tick();
    bit rdy_e, any_open, hit;
    int c, b, ref_at;
    if (rnd_ref) refresh_flag = ($urandom_range(0, 19) == 0);
    @(negedge clk);
    rdy_e = (t >= 1) && (t >= idle_at) && !pend;
    chk("cmd",         32'(cmd),         32'(e_cmd[t]));
    chk("cmd_bank",    32'(cmd_bank),    32'(e_bank[t]));
    chk("cmd_row",     32'(cmd_row),     32'(e_row[t]));
    chk("cmd_col",     32'(cmd_col),     32'(e_col[t]));
    chk("rd_valid",    32'(rd_valid),    32'(e_rdv[t]));
    chk("refresh_ack", 32'(refresh_ack), 32'(e_cmd[t] == C_REF));
    chk("req_ready",   32'(req_ready),   32'(rdy_e));
    chk("busy",        32'(busy),        32'((t < idle_at) || pend));
    if (refresh_ack) ack_obs++;
    accepted = 1'b0;
    if (t >= idle_at) begin
      if (pend) begin
        any_open = 1'b0;
        for (int i = 0; i < NB; i++) begin
          any_open |= ovld[i];
          ovld[i] = 1'b0;
        end
        if (any_open) begin
          sched(t + 1, C_PREA, 0, 0, 0);
          ref_at = t + 1 + T_RP;
        end else begin
          ref_at = t + 1;
        end
        sched(ref_at, C_REF, 0, 0, 0);
        idle_at = ref_at + T_RFC;
      end else if (req_valid && rdy_e) begin
        accepted = 1'b1;
        b   = int'(req_bank);
        hit = ovld[b] && (orow[b] == int'(req_row));
        c   = t + 1;
        if (ovld[b] && !hit) begin
          sched(c, C_PRE, b, 0, 0);
          c += T_RP;
        end
        if (!hit) begin
          sched(c, C_ACT, b, int'(req_row), 0);
          c += T_RCD;
        end
        sched(c, req_we ? C_WR : C_RD, b, 0, int'(req_col));
        idle_at = c + 1;
        ovld[b] = 1'b1;
        orow[b] = int'(req_row);
      end
    end
    pend = refresh_flag || (pend && (e_cmd[t + 1] != C_REF));
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic req(input bit we, input int b, input int r, input int co);
    req_valid = 1'b1; req_we = we;
    req_bank = BW'(b); req_row = RW'(r); req_col = CW'(co);
    for (int k = 0; k < 100 && !accepted; k++) tick();
    if (!accepted) begin
      checks++; errors++;
      $error("FAIL req_timeout cycle=%0d observed=not_accepted expected=accepted", t);
    end
    accepted  = 1'b0;
    req_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd"},   32'(cmd),         32'(C_NOP));
    chk({tag, "_bank"},  32'(cmd_bank),    32'd0);
    chk({tag, "_row"},   32'(cmd_row),     32'd0);
    chk({tag, "_col"},   32'(cmd_col),     32'd0);
    chk({tag, "_rdv"},   32'(rd_valid),    32'd0);
    chk({tag, "_ack"},   32'(refresh_ack), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready),   32'd0);
    chk({tag, "_busy"},  32'(busy),        32'd0);
  endtask

  initial begin
    int a0, gap, rr;
    rst_b = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_bank = '0; req_row = '0; req_col = '0;
    refresh_flag = 1'b0; rnd_ref = 1'b0; accepted = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_b = 1'b1;
    clear_model();
    repeat (2) tick();

    // Closed bank, then row hit, then row conflict on the same bank.
    req(1'b0, 3, 5, 2);  repeat (6) tick();
    req(1'b0, 3, 5, 2);  repeat (4) tick();
    req(1'b0, 3, 9, 4);  repeat (8) tick();

    // Refresh pending alongside a waiting request with a bank open.
    a0 = ack_obs;
    refresh_flag = 1'b1; tick(); refresh_flag = 1'b0;
    req(1'b1, 3, 9, 6);  repeat (6) tick();
    chk("t4_ref_count", 32'(ack_obs - a0), 32'd1);

    // Two refresh pulses while busy merge into one REF.
    a0 = ack_obs;
    req_valid = 1'b1; req_we = 1'b0; req_bank = 3'd6; req_row = 7'd1; req_col = 3'd7;
    tick(); req_valid = 1'b0; accepted = 1'b0;
    tick();
    refresh_flag = 1'b1; tick(); refresh_flag = 1'b0;
    tick(); tick();
    refresh_flag = 1'b1; tick(); refresh_flag = 1'b0;
    repeat (30) tick();
    chk("t5_ref_count", 32'(ack_obs - a0), 32'd1);

    // Boundary: write to the highest bank/row/column.
    req(1'b1, NB - 1, NR - 1, NC - 1); repeat (6) tick();

    // Reset while waiting tRCD, then the same request must activate again.
    req(1'b0, 2, 7, 1);
    tick();
    #2 rst_b = 1'b0;
    #1 chk_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b1;
    clear_model();
    tick();
    req(1'b0, 2, 7, 1);  repeat (6) tick();

    // Random traffic with sporadic refresh pulses.
    rnd_ref = 1'b1;
    for (int k = 0; k < 250; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      rr = ($urandom_range(0, 7) == 0) ? NR - 1 : $urandom_range(0, 3);
      req(1'($urandom_range(0, 1)), $urandom_range(0, NB - 1), rr, $urandom_range(0, NC - 1));
    end
    rnd_ref = 1'b0;
    refresh_flag = 1'b0;
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
